// File: rtl/imem_pkg.sv
// Shared instruction-memory definitions: loader FSM states and memory geometry.
// Also used by the instruction memory itself and the CPU fetch logic.
package imem_pkg;

  localparam int IMEM_BYTES = 128;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_CHECK,
    LD_FIN
  } ld_state_e;

endpackage

// File: rtl/imem_byte_writer.sv
// Registered byte-write stage for the instruction memory. Owns the running
// write address, which is seeded from base at the start of a load.
module imem_byte_writer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic [ADDR_W-1:0] base,
  input  logic              wr,
  input  logic [7:0]        wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata
);

  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [7:0]        wdata_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      we_reg <= wr;
      if (init) begin
        addr_reg <= base;
      end else if (wr) begin
        // Address and data are held after the strobe drops.
        waddr_reg <= addr_reg;
        wdata_reg <= wdata;
        addr_reg  <= addr_reg + ADDR_W'(1);
      end
    end
  end

  assign mem_we    = we_reg;
  assign mem_addr  = waddr_reg;
  assign mem_wdata = wdata_reg;

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into the instruction memory, big-endian per word, holding the CPU meanwhile.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum byte after the data.
module imem_loader #(
  parameter int ADDR_W     = 32,
  parameter int MEM_BYTES  = imem_pkg::IMEM_BYTES,
  parameter int WORD_BYTES = imem_pkg::WORD_BYTES,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  import imem_pkg::*;

  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam int TOT_W = CNT_W + OFF_W;
  localparam int CHK_W = ADDR_W + CNT_W + 2;

  ld_state_e        state_reg, state_next;
  logic [TOT_W-1:0] total_reg, total_next;
  logic [TOT_W-1:0] acc_cnt_reg, acc_cnt_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             error_reg, error_next;

  logic [CHK_W-1:0] req_end;
  logic             req_bad;
  logic             accept;
  logic             last_byte;
  logic             wr_init;
  logic             wr_en;

  // End address is computed wide enough that a huge base or count cannot wrap past the check.
  assign req_end = CHK_W'(base_addr) + (CHK_W'(word_count) << OFF_W);
  assign req_bad = (base_addr[OFF_W-1:0] != '0) || (req_end > CHK_W'(MEM_BYTES));

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign s_ready = (state_reg == LD_LOAD) || (state_reg == LD_CHECK);
`else
  assign s_ready = (state_reg == LD_LOAD);
`endif

  assign accept    = s_valid && s_ready;
  assign wr_en     = accept && (state_reg == LD_LOAD);
  assign last_byte = wr_en && (acc_cnt_reg == total_reg - TOT_W'(1));

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_reg;
  logic [7:0] sum_check;

  assign sum_check = sum_reg + s_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg <= '0;
    end else if (wr_init) begin
      sum_reg <= '0;
    end else if (wr_en) begin
      sum_reg <= sum_reg + s_data;
    end
  end
`endif

  always_comb begin
    state_next   = state_reg;
    total_next   = total_reg;
    acc_cnt_next = acc_cnt_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    error_next   = 1'b0;
    wr_init      = 1'b0;
    case (state_reg)
      LD_IDLE: begin
        if (start) begin
          if (req_bad) begin
            error_next = 1'b1;
          end else if (word_count == '0) begin
            done_next = 1'b1;
          end else begin
            state_next   = LD_LOAD;
            busy_next    = 1'b1;
            total_next   = TOT_W'(word_count) << OFF_W;
            acc_cnt_next = '0;
            wr_init      = 1'b1;
          end
        end
      end
      LD_LOAD: begin
        if (wr_en) begin
          acc_cnt_next = acc_cnt_reg + TOT_W'(1);
        end
        if (last_byte) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = LD_CHECK;
`else
          state_next = LD_FIN;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      LD_CHECK: begin
        // The checksum byte is consumed here and never reaches the memory.
        if (accept) begin
          state_next = LD_IDLE;
          busy_next  = 1'b0;
          if (sum_check == 8'h00) begin
            done_next = 1'b1;
          end else begin
            error_next = 1'b1;
          end
        end
      end
`endif
      LD_FIN: begin
        state_next = LD_IDLE;
        busy_next  = 1'b0;
        done_next  = 1'b1;
      end
      default: begin
        state_next = LD_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= LD_IDLE;
      total_reg   <= '0;
      acc_cnt_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      total_reg   <= total_next;
      acc_cnt_reg <= acc_cnt_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
    end
  end

  imem_byte_writer #(
    .ADDR_W(ADDR_W)
  ) u_writer (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (wr_init),
    .base     (base_addr),
    .wr       (wr_en),
    .wdata    (s_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata)
  );

  assign busy     = busy_reg;
  assign cpu_hold = busy_reg;
  assign done     = done_reg;
  assign error    = error_reg;

endmodule
